// File: rtl/lot_occupancy_counter.sv
// Lot occupancy counter: saturating up/down count of cars with full/empty and sticky error flags.
// Define OCCUPANCY_BCD_EN to add a serial double-dabble converter that drives two BCD digits.
module lot_occupancy_counter #(
  parameter int CAPACITY = 99,
  parameter int CNT_W    = 7
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enter,
  input  logic             exit,
  input  logic             clear,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  output logic             underflow
`ifdef OCCUPANCY_BCD_EN
  ,
  output logic [3:0]       bcd_tens,
  output logic [3:0]       bcd_ones,
  output logic             bcd_valid
`endif
);

  localparam logic [CNT_W-1:0] CAP_C = CNT_W'(CAPACITY);

  logic             enter_d_reg, exit_d_reg;
  logic             enter_ev, exit_ev;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             overflow_reg, overflow_next;
  logic             underflow_reg, underflow_next;

  assign enter_ev = enter & ~enter_d_reg;
  assign exit_ev  = exit & ~exit_d_reg;

  always_comb begin
    count_next     = count_reg;
    overflow_next  = overflow_reg;
    underflow_next = underflow_reg;
    if (clear) begin
      count_next     = '0;
      overflow_next  = 1'b0;
      underflow_next = 1'b0;
    end else if (enter_ev && exit_ev) begin
      // Simultaneous entry and exit cancel out, even at the limits.
      count_next = count_reg;
    end else if (enter_ev) begin
      if (count_reg < CAP_C) count_next = count_reg + CNT_W'(1);
      else                   overflow_next = 1'b1;
    end else if (exit_ev) begin
      if (count_reg != '0) count_next = count_reg - CNT_W'(1);
      else                 underflow_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enter_d_reg   <= 1'b0;
      exit_d_reg    <= 1'b0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      enter_d_reg   <= enter;
      exit_d_reg    <= exit;
      count_reg     <= count_next;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
    end
  end

  assign count     = count_reg;
  assign full      = (count_reg == CAP_C);
  assign empty     = (count_reg == '0);
  assign overflow  = overflow_reg;
  assign underflow = underflow_reg;

`ifdef OCCUPANCY_BCD_EN
  localparam int SR_W = CNT_W + 8;
  localparam int IT_W = $clog2(CNT_W + 1);
  localparam logic [IT_W-1:0] LAST_IT = IT_W'(CNT_W - 1);

  typedef enum logic [1:0] {BCD_IDLE, BCD_SHIFT, BCD_DONE} bcd_state_t;

  bcd_state_t       state_reg, state_next;
  logic [SR_W-1:0]  shift_reg, shift_next, shift_adj;
  logic [CNT_W-1:0] last_conv_reg, last_conv_next;
  logic [IT_W-1:0]  iter_reg, iter_next;
  logic [3:0]       tens_reg, tens_next, ones_reg, ones_next;
  logic             valid_reg, valid_next;

  // Shift register layout: {tens, ones, binary}; each BCD nibble gets its add-3 correction.
  assign shift_adj[CNT_W-1:0] = shift_reg[CNT_W-1:0];
  for (genvar gi = 0; gi < 2; gi++) begin : g_nib
    logic [3:0] nib;
    assign nib = shift_reg[CNT_W+4*gi +: 4];
    assign shift_adj[CNT_W+4*gi +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
  end

  always_comb begin
    state_next     = state_reg;
    shift_next     = shift_reg;
    last_conv_next = last_conv_reg;
    iter_next      = iter_reg;
    tens_next      = tens_reg;
    ones_next      = ones_reg;
    valid_next     = valid_reg;
    case (state_reg)
      BCD_IDLE: begin
        if (count_reg != last_conv_reg) begin
          shift_next     = {8'd0, count_reg};
          last_conv_next = count_reg;
          iter_next      = '0;
          valid_next     = 1'b0;
          state_next     = BCD_SHIFT;
        end
      end
      BCD_SHIFT: begin
        shift_next = {shift_adj[SR_W-2:0], 1'b0};
        iter_next  = iter_reg + IT_W'(1);
        if (iter_reg == LAST_IT) state_next = BCD_DONE;
      end
      BCD_DONE: begin
        tens_next  = shift_reg[CNT_W+4 +: 4];
        ones_next  = shift_reg[CNT_W +: 4];
        // Stay invalid if the count moved mid-conversion; IDLE re-converts next cycle.
        valid_next = (count_reg == last_conv_reg);
        state_next = BCD_IDLE;
      end
      default: state_next = BCD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= BCD_IDLE;
      shift_reg     <= '0;
      last_conv_reg <= '0;
      iter_reg      <= '0;
      tens_reg      <= 4'd0;
      ones_reg      <= 4'd0;
      valid_reg     <= 1'b1;
    end else begin
      state_reg     <= state_next;
      shift_reg     <= shift_next;
      last_conv_reg <= last_conv_next;
      iter_reg      <= iter_next;
      tens_reg      <= tens_next;
      ones_reg      <= ones_next;
      valid_reg     <= valid_next;
    end
  end

  assign bcd_tens  = tens_reg;
  assign bcd_ones  = ones_reg;
  assign bcd_valid = valid_reg;
`endif

endmodule

// File: tb/tb_lot_occupancy_counter.sv
// Directed bench for lot_occupancy_counter: a CAPACITY=99 instance plus a CAPACITY=5 instance for saturation.
// BCD digit checks run when OCCUPANCY_BCD_EN is defined.
module tb_lot_occupancy_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n, enter, exit, clear;
  logic       enter5, exit5, clear5;
  logic [6:0] count;
  logic       full, empty, overflow, underflow;
  logic [2:0] count5;
  logic       full5, empty5, overflow5, underflow5;
`ifdef OCCUPANCY_BCD_EN
  logic [3:0] bcd_tens, bcd_ones, bcd_tens5, bcd_ones5;
  logic       bcd_valid, bcd_valid5;
`endif

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  lot_occupancy_counter #(.CAPACITY(99), .CNT_W(7)) dut (
    .clk(clk), .reset_n(reset_n), .enter(enter), .exit(exit), .clear(clear),
    .count(count), .full(full), .empty(empty), .overflow(overflow), .underflow(underflow)
`ifdef OCCUPANCY_BCD_EN
    , .bcd_tens(bcd_tens), .bcd_ones(bcd_ones), .bcd_valid(bcd_valid)
`endif
  );

  lot_occupancy_counter #(.CAPACITY(5), .CNT_W(3)) dut5 (
    .clk(clk), .reset_n(reset_n), .enter(enter5), .exit(exit5), .clear(clear5),
    .count(count5), .full(full5), .empty(empty5), .overflow(overflow5), .underflow(underflow5)
`ifdef OCCUPANCY_BCD_EN
    , .bcd_tens(bcd_tens5), .bcd_ones(bcd_ones5), .bcd_valid(bcd_valid5)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    enter = 1'b0; exit = 1'b0; clear = 1'b0;
    enter5 = 1'b0; exit5 = 1'b0; clear5 = 1'b0;
    repeat (3) tick();
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_overflow", overflow, 0);
    check("rst_underflow", underflow, 0);
    check("rst_count5", count5, 0);
    reset_n = 1'b1;
    tick();

    // Single pulses, 4 cycles apart: count steps right after the sampling edge.
    for (int i = 1; i <= 3; i++) begin
      enter = 1'b1;
      check("enter_pre", count, i - 1);
      tick();
      enter = 1'b0;
      check("enter_step", count, i);
      $display("enter pulse %0d: count=%0d", i, count);
      repeat (3) tick();
    end
    enter = 1'b1;
    repeat (10) tick();
    check("enter_held", count, 4);
    enter = 1'b0;
    tick();
    check("enter_held_release", count, 4);
    check("not_empty", empty, 0);

    // Down to 2, then simultaneous enter+exit.
    for (int i = 1; i <= 2; i++) begin
      exit = 1'b1; tick(); exit = 1'b0; tick();
      check("exit_step", count, 4 - i);
      $display("exit pulse %0d: count=%0d", i, count);
    end
    enter = 1'b1; exit = 1'b1; tick(); enter = 1'b0; exit = 1'b0; tick();
    check("both_at_2", count, 2);
    check("both_at_2_ovf", overflow, 0);
    for (int i = 1; i <= 2; i++) begin
      exit = 1'b1; tick(); exit = 1'b0; tick();
    end
    check("exit_to_0", count, 0);
    check("exit_to_0_empty", empty, 1);
    enter = 1'b1; exit = 1'b1; tick(); enter = 1'b0; exit = 1'b0; tick();
    check("both_at_0", count, 0);
    check("both_at_0_unf", underflow, 0);

    // Underflow is sticky across a later enter.
    exit = 1'b1; tick(); exit = 1'b0; tick();
    check("unf_count", count, 0);
    check("unf_flag", underflow, 1);
    enter = 1'b1; tick(); enter = 1'b0; tick();
    check("unf_then_enter_count", count, 1);
    check("unf_sticky", underflow, 1);
    $display("underflow sequence: count=%0d underflow=%0d", count, underflow);

    // Clear wins over a simultaneous enter.
    clear = 1'b1; enter = 1'b1; tick(); clear = 1'b0; enter = 1'b0;
    check("clear_count", count, 0);
    check("clear_unf", underflow, 0);
    tick();
    check("clear_after", count, 0);

    // Saturation on the CAPACITY=5 instance.
    for (int i = 1; i <= 6; i++) begin
      enter5 = 1'b1; tick(); enter5 = 1'b0; tick();
      check("sat_count", count5, (i < 5) ? i : 5);
      check("sat_full", full5, (i >= 5) ? 1 : 0);
      check("sat_ovf", overflow5, (i == 6) ? 1 : 0);
      $display("cap5 enter %0d: count=%0d full=%0d overflow=%0d", i, count5, full5, overflow5);
    end
    check("sat_not_empty", empty5, 0);
    clear5 = 1'b1; tick(); clear5 = 1'b0;
    check("sat_clear_count", count5, 0);
    check("sat_clear_ovf", overflow5, 0);
    check("sat_clear_empty", empty5, 1);
    check("sat_clear_full", full5, 0);

`ifdef OCCUPANCY_BCD_EN
    for (int i = 1; i <= 46; i++) begin
      enter = 1'b1; tick(); enter = 1'b0; tick();
    end
    repeat (20) tick();
    check("bcd46_count", count, 46);
    check("bcd46_tens", bcd_tens, 4);
    check("bcd46_ones", bcd_ones, 6);
    check("bcd46_valid", bcd_valid, 1);
    enter = 1'b1; tick(); enter = 1'b0;
    check("bcd47_count", count, 47);
    check("bcd47_valid_same", bcd_valid, 1);
    tick();
    check("bcd47_valid_fall", bcd_valid, 0);
    repeat (7) tick();
    check("bcd47_valid_late", bcd_valid, 0);
    tick();
    check("bcd47_valid", bcd_valid, 1);
    check("bcd47_tens", bcd_tens, 4);
    check("bcd47_ones", bcd_ones, 7);
    $display("bcd conversion: count=%0d digits=%0d%0d", count, bcd_tens, bcd_ones);
    enter = 1'b1; tick(); enter = 1'b0;
    repeat (3) tick();
    check("bcd48_busy", bcd_valid, 0);
    reset_n = 1'b0;
    #1;
    check("bcd_rst_count", count, 0);
    check("bcd_rst_tens", bcd_tens, 0);
    check("bcd_rst_ones", bcd_ones, 0);
    check("bcd_rst_valid", bcd_valid, 1);
    tick();
    reset_n = 1'b1;
    tick();
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
